cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of functional-unit requesters sharing the CDB.
REQ-002 Parameter TAG_W, default 5: reorder-buffer tag width.
REQ-003 Parameter DATA_W, default 32: result data width.
REQ-004 clock  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 Req_cdb  in  NUM_REQ  per-requester result-ready request, level-sensitive.
REQ-007 Tag_cdb  in  NUM_REQ*TAG_W  per-requester result tag; requester i occupies bits [i*TAG_W +: TAG_W].
REQ-008 Data_cdb  in  NUM_REQ*DATA_W  per-requester result data, packed the same way as Tag_cdb.
REQ-009 Hold_cdb  in  1  downstream stall; no broadcast is issued while high.
REQ-010 Ack_cdb  out  NUM_REQ  registered one-hot grant pulse.
REQ-011 CDB_tag  out  TAG_W  registered broadcast tag (to RB_tag_rst).
REQ-012 CDB_data  out  DATA_W  registered broadcast data.
REQ-013 CDB_valid  out  1  registered broadcast valid (to RB_valid_rst).

Function
REQ-014 Each cycle, the eligible set SHALL be Req_cdb & ~Ack_cdb (a requester being acked this cycle is masked).
REQ-015 If Hold_cdb=0 and the eligible set is non-zero, exactly one winner SHALL be selected by round-robin, starting search at pointer P and wrapping from NUM_REQ-1 to 0.
REQ-016 At the next edge the winner's tag and data SHALL be registered onto CDB_tag/CDB_data, CDB_valid=1, Ack_cdb[winner]=1 (latency 1 cycle from request to broadcast).
REQ-017 After a grant, P SHALL become (winner+1) mod NUM_REQ; with no grant, P SHALL be unchanged.
REQ-018 With no grant (empty eligible set or Hold_cdb=1), CDB_valid and Ack_cdb SHALL be 0 the next cycle, and CDB_tag/CDB_data SHALL hold their previous values.
REQ-019 Ack_cdb SHALL be at most one-hot and SHALL always equal the source of the current CDB_valid broadcast.
REQ-020 A requester SHALL hold Req, Tag and Data stable until it sees its Ack, and SHALL deassert Req in the ack cycle unless it has a new result.
REQ-021 Hold_cdb asserted in the same cycle as a request SHALL defer that request with no loss; Hold_cdb does not cancel a broadcast already on the outputs.
REQ-022 A single continuous requester SHALL be granted at most every other cycle, because of the REQ-014 mask.

Reset
REQ-023 While reset=0: CDB_valid=0, Ack_cdb=0, CDB_tag=0, CDB_data=0, P=0.
REQ-024 Reset asserted mid-broadcast SHALL clear outputs immediately; a pending request SHALL be re-arbitrated from P=0 after release.

Configuration
REQ-025 Macro CDB_FIXED_PRIO_EN: when defined, selection SHALL be fixed priority (lowest index wins) and P SHALL be absent.
REQ-026 When the macro is not defined, selection SHALL be round-robin as in REQ-015 to REQ-017; all other behaviour is identical in both builds.

Structure
REQ-027 Package cdb_pkg SHALL hold NUM_REQ, TAG_W and DATA_W defaults, plus the CDB token type {valid, tag} that matches the RST CDB_Token format.
REQ-028 The combinational winner search SHALL be one sub-module, rr_pick, with inputs eligible vector and P, and outputs one-hot grant, encoded index and any-grant flag.
REQ-029 The payload mux and output registers SHALL reside in cdb_arbiter.

Verification
REQ-030 Reset release, Req=0000 for 5 cycles -> CDB_valid=0, Ack=0000 throughout.
REQ-031 Req=0100, Tag2=5'd9, Data2=32'hDEADBEEF -> next cycle CDB_valid=1, CDB_tag=9, CDB_data=DEADBEEF, Ack=0100.
REQ-032 Req=1111 held continuously from P=0 -> grant order 0,1,2,3,0; each Ack is one-hot and the tag matches the source. Under CDB_FIXED_PRIO_EN the same stimulus -> grant order 0,1,0,1.
REQ-033 Req=0011 with Hold_cdb=1 for 3 cycles, then 0 -> no valid during the hold, then requester 0 granted, then requester 1; no request is lost.
REQ-034 Reset=0 asserted during a CDB_valid=1 cycle with Req=1000 pending -> outputs clear asynchronously; after release, requester 3 is granted one cycle later.
REQ-035 Continuous Req=0001 alone -> Ack pattern 1,0,1,0 and CDB_valid pattern 1,0,1,0.

Source files
------------

// File: rtl/cdb_pkg.sv
// cdb_pkg: shared defaults and the CDB token type for the common data bus arbiter.
// Build option: define CDB_FIXED_PRIO_EN for fixed-priority selection (see cdb_arbiter).
package cdb_pkg;

    localparam int CDB_NUM_REQ = 4;   // functional units sharing the CDB
    localparam int CDB_TAG_W   = 5;   // reorder-buffer tag width
    localparam int CDB_DATA_W  = 32;  // result data width

    // Token seen by the reorder buffer: broadcast valid plus the tag being retired.
    typedef struct packed {
        logic                 valid;
        logic [CDB_TAG_W-1:0] tag;
    } cdb_token_t;

    // Width of an index into NUM_REQ requesters, never zero.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational winner search. Scans the eligible vector starting
// at i_ptr and wrapping from N-1 to 0; the first set bit wins.
// With i_ptr tied to zero this degenerates to lowest-index-wins priority.
module rr_pick
    import cdb_pkg::*;
#(
    parameter int N     = CDB_NUM_REQ,
    parameter int IDX_W = idx_width(CDB_NUM_REQ)
) (
    input  logic [N-1:0]     i_eligible,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Rotating first-set search; later candidates are ignored once one is found.
    always_comb begin
        int w_j;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        for (int off = 0; off < N; off++) begin
            w_j = int'(i_ptr) + off;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            if (!o_any && i_eligible[w_j]) begin
                o_any        = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = IDX_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: picks one finished functional unit per cycle and broadcasts
// its tag/data on the common data bus one cycle later, with a one-hot Ack
// pulse back to the winner.
// Handshake: a requester holds Req/Tag/Data stable until it sees its Ack
// bit; the Ack cycle is also the broadcast cycle, and the acked requester is
// masked from arbitration in that cycle, so it must drop Req unless it
// already has a new result. Hold_cdb blocks new grants but never retracts
// the broadcast already on the outputs.
// Build option: CDB_FIXED_PRIO_EN selects lowest-index-wins priority and
// removes the round-robin pointer.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ = CDB_NUM_REQ,
    parameter int TAG_W   = CDB_TAG_W,
    parameter int DATA_W  = CDB_DATA_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        Req_cdb,
    input  logic [NUM_REQ*TAG_W-1:0]  Tag_cdb,
    input  logic [NUM_REQ*DATA_W-1:0] Data_cdb,
    input  logic                      Hold_cdb,
    output logic [NUM_REQ-1:0]        Ack_cdb,
    output logic [TAG_W-1:0]          CDB_tag,
    output logic [DATA_W-1:0]         CDB_data,
    output logic                      CDB_valid
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0] r_ack;
    logic               r_valid;
    logic [TAG_W-1:0]   r_tag;
    logic [DATA_W-1:0]  r_data;

    logic [NUM_REQ-1:0] w_eligible;
    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_ptr;
    logic               w_any;
    logic               w_fire;
    logic [TAG_W-1:0]   w_tag_sel;
    logic [DATA_W-1:0]  w_data_sel;

    // A requester being acked right now is already on the bus; mask it.
    assign w_eligible = Req_cdb & ~r_ack;
    assign w_fire     = w_any & ~Hold_cdb;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_eligible (w_eligible),
        .i_ptr      (w_ptr),
        .o_grant    (w_grant),
        .o_idx      (w_idx),
        .o_any      (w_any)
    );

`ifdef CDB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [IDX_W-1:0] r_ptr;

    // Round-robin pointer moves just past the winner on every grant.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (w_fire) begin
            r_ptr <= (w_idx == LAST_IDX) ? '0 : w_idx + 1'b1;
        end
    end

    assign w_ptr = r_ptr;
`endif

    // One-hot grant steers the winner's payload onto the bus registers.
    always_comb begin
        w_tag_sel  = '0;
        w_data_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_tag_sel  = Tag_cdb[i*TAG_W +: TAG_W];
                w_data_sel = Data_cdb[i*DATA_W +: DATA_W];
            end
        end
    end

    // Broadcast registers: valid/ack pulse per grant, payload holds when idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_ack   <= '0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (w_fire) begin
            r_valid <= 1'b1;
            r_ack   <= w_grant;
            r_tag   <= w_tag_sel;
            r_data  <= w_data_sel;
        end else begin
            r_valid <= 1'b0;
            r_ack   <= '0;
        end
    end

    assign Ack_cdb   = r_ack;
    assign CDB_valid = r_valid;
    assign CDB_tag   = r_tag;
    assign CDB_data  = r_data;

endmodule
